// File: rtl/axil_reg_bank.sv
// AXI4-Lite slave register bank: NUM_REGS word registers driven to fabric, read-only
// slots return fabric status, out-of-range or read-only writes answer SLVERR.
module axil_reg_bank #(
  parameter int                              ADDR_WIDTH = 12,
  parameter int                              DATA_WIDTH = 32,
  parameter int                              NUM_REGS   = 16,
  parameter logic [NUM_REGS-1:0]             RO_MASK    = '0,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0]  RESET_VAL  = '0
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic [ADDR_WIDTH-1:0]          awaddr,
  input  logic [2:0]                     awprot,
  input  logic                           awvalid,
  output logic                           awready,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [DATA_WIDTH/8-1:0]        wstrb,
  input  logic                           wvalid,
  output logic                           wready,
  output logic [1:0]                     bresp,
  output logic                           bvalid,
  input  logic                           bready,
  input  logic [ADDR_WIDTH-1:0]          araddr,
  input  logic [2:0]                     arprot,
  input  logic                           arvalid,
  output logic                           arready,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [1:0]                     rresp,
  output logic                           rvalid,
  input  logic                           rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_in,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int ADDR_LSB   = $clog2(STRB_WIDTH);
  localparam int IDX_W      = ADDR_WIDTH - ADDR_LSB;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_t;

  // Valid/ready: a transfer happens on a rising aclk edge where both are high; a
  // source holds valid and its payload stable until that edge.

  regs_t                 regs_q, regs_d;
  logic                  aw_full_q, aw_full_d;
  logic [IDX_W-1:0]      aw_idx_q, aw_idx_d;
  logic                  w_full_q, w_full_d;
  logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
  logic [STRB_WIDTH-1:0] w_strb_q, w_strb_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [NUM_REGS-1:0]   wr_pulse_q, wr_pulse_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;

  logic                  aw_hs, w_hs, ar_hs, commit, wr_hit;
  logic [IDX_W-1:0]      awaddr_idx, araddr_idx, c_idx;
  logic [DATA_WIDTH-1:0] c_data;
  logic [STRB_WIDTH-1:0] c_strb;
  logic                  unused_ok;

  assign awready    = !aw_full_q && !bvalid_q;
  assign wready     = !w_full_q && !bvalid_q;
  assign arready    = !rvalid_q;
  assign aw_hs      = awvalid && awready;
  assign w_hs       = wvalid && wready;
  assign ar_hs      = arvalid && arready;
  assign awaddr_idx = awaddr[ADDR_WIDTH-1:ADDR_LSB];
  assign araddr_idx = araddr[ADDR_WIDTH-1:ADDR_LSB];

  // Commit uses the held half if present, otherwise the half arriving this cycle.
  assign commit = (aw_full_q || aw_hs) && (w_full_q || w_hs);
  assign c_idx  = aw_full_q ? aw_idx_q : awaddr_idx;
  assign c_data = w_full_q ? w_data_q : wdata;
  assign c_strb = w_full_q ? w_strb_q : wstrb;

  assign unused_ok = ^{awprot, arprot, awaddr[ADDR_LSB-1:0], araddr[ADDR_LSB-1:0]};

  always_comb begin
    aw_full_d  = aw_full_q;
    aw_idx_d   = aw_idx_q;
    w_full_d   = w_full_q;
    w_data_d   = w_data_q;
    w_strb_d   = w_strb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    regs_d     = regs_q;
    wr_pulse_d = '0;
    wr_hit     = 1'b0;
    if (bvalid_q && bready) bvalid_d = 1'b0;
    if (aw_hs) begin
      aw_full_d = 1'b1;
      aw_idx_d  = awaddr_idx;
    end
    if (w_hs) begin
      w_full_d = 1'b1;
      w_data_d = wdata;
      w_strb_d = wstrb;
    end
    if (commit) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (c_idx == IDX_W'(i) && !RO_MASK[i]) begin
          wr_hit        = 1'b1;
          wr_pulse_d[i] = 1'b1;
          for (int k = 0; k < STRB_WIDTH; k++) begin
            if (c_strb[k]) regs_d[i][8*k +: 8] = c_data[8*k +: 8];
          end
        end
      end
      bresp_d = wr_hit ? RESP_OKAY : RESP_SLVERR;
    end
  end

  // Reads sample regs_q, so a same-cycle write to the same register is not visible yet.
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (rvalid_q && rready) rvalid_d = 1'b0;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = '0;
      rresp_d  = RESP_SLVERR;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (araddr_idx == IDX_W'(i)) begin
          rresp_d = RESP_OKAY;
          rdata_d = RO_MASK[i] ? reg_in[i*DATA_WIDTH +: DATA_WIDTH] : regs_q[i];
        end
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      regs_q     <= regs_t'(RESET_VAL);
      aw_full_q  <= 1'b0;
      aw_idx_q   <= '0;
      w_full_q   <= 1'b0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      wr_pulse_q <= '0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
    end else begin
      regs_q     <= regs_d;
      aw_full_q  <= aw_full_d;
      aw_idx_q   <= aw_idx_d;
      w_full_q   <= w_full_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      wr_pulse_q <= wr_pulse_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  assign bvalid   = bvalid_q;
  assign bresp    = bresp_q;
  assign rvalid   = rvalid_q;
  assign rdata    = rdata_q;
  assign rresp    = rresp_q;
  assign wr_pulse = wr_pulse_q;
  assign reg_out  = regs_q;

endmodule

// File: tb/tb_axil_reg_bank.sv
// Directed bench for axil_reg_bank: reset state, strobed writes, split AW/W ordering,
// backpressure, SLVERR cases, read-only status, read/write collision and mid-flight reset.
module tb_axil_reg_bank;

  localparam int NR = 16;
  localparam int DW = 32;
  localparam logic [NR-1:0]    RO    = 16'h0008;
  localparam logic [NR*DW-1:0] RST_V = 512'hA5A5_0000 << 64;

  logic            aclk, aresetn;
  logic [11:0]     awaddr, araddr;
  logic [2:0]      awprot, arprot;
  logic            awvalid, awready, wvalid, wready, bvalid, bready;
  logic            arvalid, arready, rvalid, rready;
  logic [DW-1:0]   wdata, rdata;
  logic [DW/8-1:0] wstrb;
  logic [1:0]      bresp, rresp;
  logic [NR*DW-1:0] reg_out, reg_in, exp_regs;
  logic [NR-1:0]   wr_pulse;

  logic [DW-1:0] exp_q[$];
  int n_vec, n_err;

  axil_reg_bank #(
    .ADDR_WIDTH(12), .DATA_WIDTH(DW), .NUM_REGS(NR), .RO_MASK(RO), .RESET_VAL(RST_V)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .reg_out(reg_out), .reg_in(reg_in), .wr_pulse(wr_pulse)
  );

  // clock / reset
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [NR*DW-1:0] obs, input logic [NR*DW-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // driver tasks
  task automatic do_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp, output logic [NR-1:0] pulse);
    int cyc;
    logic aw_hs, w_hs;
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0; cyc = 0;
    while ((awvalid || wvalid) && cyc < 20) begin
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      tick();
      cyc++;
      if (aw_hs) awvalid = 1'b0;
      if (w_hs)  wvalid  = 1'b0;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    check("b_latency", bvalid, 1'b1);
    resp  = bresp;
    pulse = wr_pulse;
    bready = 1'b1;
    tick();
    bready = 1'b0;
  endtask

  task automatic do_read(input string tag, input logic [11:0] a, output logic [1:0] resp);
    logic [DW-1:0] exp;
    araddr = a; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    check("r_latency", rvalid, 1'b1);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check(tag, rdata, exp);
    resp = rresp;
    rready = 1'b1;
    tick();
    rready = 1'b0;
  endtask

  initial begin
    logic [1:0]    resp;
    logic [NR-1:0] pulse;
    logic          stable, any_b;
    logic [NR-1:0] pulses;
    n_vec = 0; n_err = 0;
    aresetn = 1'b0;
    awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
    bready = 1'b0; araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
    reg_in = 512'hDEAD_BEEF << 96;
    exp_regs = RST_V;
    repeat (3) tick();
    check("rst_bvalid", bvalid, 1'b0);
    check("rst_rvalid", rvalid, 1'b0);
    aresetn = 1'b1;
    tick();
    check("rst_bresp", bresp, 2'b00);
    check("rst_rresp", rresp, 2'b00);
    check("rst_rdata", rdata, 32'h0);
    check("rst_pulse", wr_pulse, 16'h0);
    check("rst_regs", reg_out, RST_V);
    check("rst_awready", awready, 1'b1);
    check("rst_wready", wready, 1'b1);
    check("rst_arready", arready, 1'b1);

    // reset value readback
    exp_q.push_back(32'hA5A5_0000);
    do_read("rd_reg2", 12'h008, resp);
    check("rd_reg2_resp", resp, 2'b00);

    // strobed write: bytes 0 and 2 only
    do_write(12'h004, 32'h1122_3344, 4'b0101, resp, pulse);
    check("wr1_bresp", resp, 2'b00);
    check("wr1_pulse", pulse, 16'h0002);
    check("wr1_pulse_end", wr_pulse, 16'h0);
    exp_regs[32 +: 32] = 32'h0022_0044;
    check("wr1_regs", reg_out, exp_regs);

    // W three cycles ahead of AW, then B held off for five cycles
    wdata = 32'hCAFE_F00D; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    check("wearly_wready", wready, 1'b0);
    tick();
    tick();
    check("wearly_nob", bvalid, 1'b0);
    check("wearly_awready", awready, 1'b1);
    awaddr = 12'h010; awvalid = 1'b1; bready = 1'b0;
    tick();
    awvalid = 1'b0;
    check("wearly_bvalid", bvalid, 1'b1);
    check("wearly_pulse", wr_pulse, 16'h0010);
    stable = 1'b1; pulses = '0;
    for (int i = 0; i < 5; i++) begin
      tick();
      stable &= (bvalid === 1'b1) && (bresp === 2'b00) && (awready === 1'b0) && (wready === 1'b0);
      pulses |= wr_pulse;
    end
    check("bhold_stable", stable, 1'b1);
    check("bhold_nopulse", pulses, 16'h0);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    check("bdone_bvalid", bvalid, 1'b0);
    check("bdone_awready", awready, 1'b1);
    check("bdone_wready", wready, 1'b1);
    exp_regs[128 +: 32] = 32'hCAFE_F00D;
    check("wearly_regs", reg_out, exp_regs);

    // out of range
    do_write(12'h040, 32'hFFFF_FFFF, 4'hF, resp, pulse);
    check("oor_bresp", resp, 2'b10);
    check("oor_pulse", pulse, 16'h0);
    check("oor_regs", reg_out, exp_regs);
    exp_q.push_back(32'h0);
    do_read("oor_rdata", 12'h040, resp);
    check("oor_rresp", resp, 2'b10);

    // read-only register 3
    do_write(12'h00C, 32'h1234_5678, 4'hF, resp, pulse);
    check("ro_bresp", resp, 2'b10);
    check("ro_pulse", pulse, 16'h0);
    check("ro_regs", reg_out, exp_regs);
    exp_q.push_back(32'hDEAD_BEEF);
    do_read("ro_rdata", 12'h00C, resp);
    check("ro_rresp", resp, 2'b00);

    // same-cycle write and read of reg 0
    do_write(12'h000, 32'h5, 4'hF, resp, pulse);
    check("r0_bresp", resp, 2'b00);
    exp_regs[0 +: 32] = 32'h5;
    awaddr = 12'h000; wdata = 32'h7; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 12'h000; arvalid = 1'b1; bready = 1'b0; rready = 1'b0;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    check("coll_rvalid", rvalid, 1'b1);
    check("coll_rdata", rdata, 32'h5);
    check("coll_bvalid", bvalid, 1'b1);
    bready = 1'b1; rready = 1'b1;
    tick();
    bready = 1'b0; rready = 1'b0;
    exp_regs[0 +: 32] = 32'h7;
    check("coll_regs", reg_out, exp_regs);
    exp_q.push_back(32'h7);
    do_read("coll_reread", 12'h000, resp);

    // reset while a write response is pending
    awaddr = 12'h014; wdata = 32'h99; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    check("mid_bvalid", bvalid, 1'b1);
    #2;
    aresetn = 1'b0;
    #1;
    check("mid_rst_bvalid", bvalid, 1'b0);
    check("mid_rst_regs", reg_out, RST_V);
    check("mid_rst_pulse", wr_pulse, 16'h0);
    tick();
    tick();
    aresetn = 1'b1;
    bready = 1'b1;
    any_b = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      any_b |= bvalid;
    end
    bready = 1'b0;
    check("mid_no_b", any_b, 1'b0);
    exp_regs = RST_V;
    check("mid_regs", reg_out, exp_regs);
    exp_q.push_back(32'h0);
    do_read("mid_reg1", 12'h004, resp);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
